pulse_meas: RTL
===============

# pulse_meas

Pulse-interval measurement block: the receiving end of the team's trigger-to-pulse one-shot path. It is armed by a falling edge on `trig`, counts clock cycles until a rising edge arrives on `inpulse`, and presents the count on a held result with a valid/ack handshake. A programmable timeout closes the measurement when no pulse arrives. It sits beside the one-shot timers for loopback checking of programmed delays and for measuring externally generated pulse intervals.

## Interface
- `N`, default 8: width of the count, limit and result.
- `clk` input 1: sole clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `trig` input 1: start request; a falling edge arms a measurement.
- `inpulse` input 1: stop event; a rising edge ends a measurement.
- `limit` input N: timeout in cycles; 0 means 2^N-1; sampled when a measurement starts.
- `ack` input 1: consumer accepts the result.
- `meas` output N: measured interval in clock edges.
- `timeout` output 1: result closed by timeout, not by a pulse.
- `valid` output 1: `meas` and `timeout` are valid and held.
- `busy` output 1: measurement in progress.

## Operation
- Edge detection: registered copies `trig_r` and `inpulse_r`. start = `trig_r & ~trig`. stop = `inpulse & ~inpulse_r`.
- FSM states: IDLE, COUNT, DONE.
- IDLE -> COUNT on start: `cnt <= 1`, `lim_q <= (limit==0 ? 2^N-1 : limit)`.
- COUNT on stop: `meas <= cnt`, `timeout <= 0`, go to DONE.
- COUNT with no stop and `cnt == lim_q`: `meas <= lim_q`, `timeout <= 1`, go to DONE.
- COUNT otherwise: `cnt <= cnt + 1`. `cnt` never wraps because the timeout check takes effect first.
- DONE: `valid = 1`. `meas` and `timeout` are held stable. On `ack` sampled high, go to IDLE and clear `valid`.
- Result: `meas = k`, where k is the number of clock edges from the start-detect edge to the stop-detect edge (stop sampled one edge after start gives `meas = 1`).
- Stop and timeout on the same edge: stop wins, so `timeout = 0` and `meas = lim_q`.
- Start and stop on the same edge in IDLE: start is taken and that stop is ignored.
- Start while in COUNT or DONE: ignored. No queuing and no restart.
- Stop while in IDLE or DONE: ignored.
- `ack` outside DONE: ignored.
- `limit` changes during COUNT: no effect.
- `busy = 1` exactly when the state is COUNT.

## Timing
- Reset (`rst == 0` at an edge):
  - State goes to IDLE.
  - `cnt`, `lim_q`, `meas`, `timeout`, `valid`, `busy`, `trig_r`, `inpulse_r` all go to 0.
  - Reset mid-measurement aborts it; no result is produced.
- Because `trig_r` resets to 0, `trig` held low through and after reset does not start a measurement. A start needs `trig` sampled 1 and then 0.
- Start latency: `trig` sampled 0 at edge E0 after being 1 at E-1 means `busy = 1` after E0.
- Result latency: stop sampled at Ek means `valid = 1`, `busy = 0`, `meas = k` after Ek.
- Handshake:
  - `ack` sampled at Ek+1 or later.
  - `ack` at edge Ea means `valid = 0` after Ea.
  - A start sampled at Ea itself is ignored, because the state is still DONE.
  - A start at Ea+1 or later is accepted.
- Back-to-back: minimum start-to-start spacing is k+2 edges (k count edges, one DONE edge with `ack` high, one IDLE edge). `ack` held high continuously gives that rate.
- All outputs are registered. No combinational path from input to output.

## Test plan
- Basic interval, N=8, limit=20:
  - Stimulus: `trig` 1->0 sampled at E0, `inpulse` 0->1 sampled at E5.
  - Required: `busy` high after E0 through E5; after E5 `valid = 1`, `meas = 5`, `timeout = 0`; result held until `ack`; `valid` falls one edge after `ack`.
- Timeout, limit=6, no `inpulse`:
  - Required: after E6 `valid = 1`, `meas = 6`, `timeout = 1`.
  - Repeat with limit=0: `meas = 255`, `timeout = 1`.
- Boundary, limit=6, stop sampled exactly at E6:
  - Required: `meas = 6`, `timeout = 0`.
  - Stop sampled at E1: `meas = 1`.
- Ignored events:
  - Second `trig` falling edge during COUNT: `meas` is unchanged from the single-start value.
  - `inpulse` edge in IDLE: no `valid`.
  - Start and stop on the same edge: measurement runs on to the next stop.
  - `ack` with `valid = 0`: no effect.
- Reset behaviour:
  - Reset asserted at E3 of a running measurement: all outputs 0 and no `valid` afterwards.
  - `trig` held low across reset release: no start.
  - A following clean 1->0 on `trig` measures correctly.
- Back-to-back with `ack` tied high, intervals 3, 7, 2:
  - Required: three results `meas = 3, 7, 2`, each `valid` for exactly one cycle.
  - Required: starts arriving during DONE are dropped.

Source files
------------

// File: rtl/pulse_meas.sv
// Pulse-interval measurement: a falling edge on trig arms a cycle counter, a rising edge on
// inpulse (or the programmed limit) closes it, and the result is held until acknowledged.
module pulse_meas #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic         inpulse,
  input  logic [N-1:0] limit,
  input  logic         ack,
  output logic [N-1:0] meas,
  output logic         timeout,
  output logic         valid,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e         state_q, state_d;
  logic           trig_r, inpulse_r;
  logic [N-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   lim_q, lim_d;
  logic [N-1:0]   meas_q, meas_d;
  logic           timeout_q, timeout_d;
  logic           valid_q, busy_q;
  logic           start, stop;

  assign start = trig_r & ~trig;
  assign stop  = inpulse & ~inpulse_r;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lim_d     = lim_q;
    meas_d    = meas_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCount;
          cnt_d   = N'(1);
          // A zero limit selects the longest possible window.
          lim_d   = (limit == '0) ? '1 : limit;
        end
      end
      StCount: begin
        // Stop is tested first so a pulse on the final cycle is not reported as a timeout.
        if (stop) begin
          meas_d    = cnt_q;
          timeout_d = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == lim_q) begin
          meas_d    = lim_q;
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + N'(1);
        end
      end
      StDone: begin
        if (ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      trig_r    <= 1'b0;
      inpulse_r <= 1'b0;
      cnt_q     <= '0;
      lim_q     <= '0;
      meas_q    <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_r    <= trig;
      inpulse_r <= inpulse;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      meas_q    <= meas_d;
      timeout_q <= timeout_d;
      valid_q   <= (state_d == StDone);
      busy_q    <= (state_d == StCount);
    end
  end

  assign meas    = meas_q;
  assign timeout = timeout_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule
